keypad_event_queue: RTL

- Consumer side of the 5x5 keypad scanner: takes its debounced {keyCode, ready} pair and turns level-held keys into discrete press/release events.
- Events queue in a small FIFO read by the CPU-side peripheral bus wrapper.
- Raises an interrupt while events are pending.
- Tracks a sticky overflow flag.

---
 rtl/keypad_event_queue_pkg.sv | 34 +++
 rtl/keypad_event_queue_if.sv | 41 ++++
 rtl/keypad_event_queue_sync_fifo.sv | 71 +++++++
 rtl/keypad_event_queue.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/keypad_event_queue_pkg.sv
// Shared definitions for the keypad event queue: FSM encoding, event layout
// and key-code helpers used by the queue and by other keypad consumers.
package keypad_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_SWAP = 2'd2;

    localparam int EV_REPEAT  = 7;
    localparam int EV_RELEASE = 6;

    localparam logic [2:0] KEY_INVALID = 3'h7;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } key_code_t;

    typedef logic [7:0] key_event_t;

    function automatic logic key_is_valid(input logic ready, input key_code_t code);
        return ready && (code.row != KEY_INVALID) && (code.col != KEY_INVALID);
    endfunction

    function automatic key_event_t make_event(input logic is_repeat, input logic is_release,
                                              input key_code_t code);
        key_event_t ev;
        ev             = {2'b00, code};
        ev[EV_REPEAT]  = is_repeat;
        ev[EV_RELEASE] = is_release;
        return ev;
    endfunction

endpackage

// File: rtl/keypad_event_queue_if.sv
// Scanner-input and CPU-read signal bundle of the keypad event queue.
// The slave modport is the queue itself; master is the scanner/bus side.
interface keypad_event_queue_if #(
    parameter int DEPTH_LOG2 = 3
);

    logic [5:0]          keyCode;
    logic                keyReady;
    logic                rd_en;
    logic                clr_ovf;
    logic [7:0]          rd_data;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                irq;

    modport slave (
        input  keyCode,
        input  keyReady,
        input  rd_en,
        input  clr_ovf,
        output rd_data,
        output empty,
        output count,
        output overflow,
        output irq
    );

    modport master (
        output keyCode,
        output keyReady,
        output rd_en,
        output clr_ovf,
        input  rd_data,
        input  empty,
        input  count,
        input  overflow,
        input  irq
    );

endinterface

// File: rtl/keypad_event_queue_sync_fifo.sv
// sync_fifo: generic show-ahead synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [WIDTH-1:0]    data_i,
    input  logic                pop_i,
    output logic [WIDTH-1:0]    data_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                empty_o,
    output logic                full_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pop is evaluated first so a full FIFO can take a push in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: the storage is reset because the show-ahead head output
            // must read as zero out of reset, not as uninitialised contents.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/keypad_event_queue.sv
// Turns the scanner's level-held key code into press/release events queued for the CPU.
// Optional auto-repeat events are built in when KEYQ_REPEAT_EN is defined.
module keypad_event_queue
    import keypad_pkg::*;
#(
    parameter int DEPTH_LOG2    = 3,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input logic                 clk,
    input logic                 rst_n,
    keypad_event_queue_if.slave bus
);

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    key_code_t           held_q;
    key_code_t           held_d;
    key_code_t           key_in;
    logic                key_valid;
    logic                hold_same;
    logic                rpt_fire;
    logic                push;
    key_event_t          push_data;
    logic                ovf_q;
    logic                ovf_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic [7:0]          fifo_head;
    logic [DEPTH_LOG2:0] fifo_count;

    assign key_in    = key_code_t'(bus.keyCode);
    assign key_valid = key_is_valid(bus.keyReady, key_in);
    assign hold_same = (state_q == ST_HELD) && key_valid && (key_in == held_q);

`ifdef KEYQ_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(RPT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_d;
    logic             rpt_armed_q;
    logic             rpt_armed_d;

    // Counter only runs while the same key stays held; anything else clears it.
    // After the first repeat the spacing switches from DELAY to PERIOD.
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
        rpt_fire    = 1'b0;
        if (hold_same) begin
            if (rpt_cnt_q == (rpt_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d   = rpt_cnt_q + 1'b1;
                rpt_armed_d = rpt_armed_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    push      = 1'b1;
                    push_data = make_event(1'b0, 1'b0, key_in);
                    held_d    = key_in;
                    state_d   = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!key_valid) begin
                    push      = 1'b1;
                    push_data = make_event(1'b0, 1'b1, held_q);
                    state_d   = ST_IDLE;
                end else if (key_in != held_q) begin
                    push      = 1'b1;
                    push_data = make_event(1'b0, 1'b1, held_q);
                    held_d    = key_in;
                    state_d   = ST_SWAP;
                end else if (rpt_fire) begin
                    push      = 1'b1;
                    push_data = make_event(1'b1, 1'b0, held_q);
                end
            end
            ST_SWAP: begin
                // Press of the new key goes out even if it vanished meanwhile.
                push      = 1'b1;
                push_data = make_event(1'b0, 1'b0, held_q);
                state_d   = (key_valid && (key_in == held_q)) ? ST_HELD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A drop happens only when full with no pop to make room; set wins over clear.
    assign ovf_d = (push && fifo_full && !bus.rd_en) | (ovf_q & ~bus.clr_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (bus.rd_en),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.rd_data  = fifo_head;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = ovf_q;
    assign bus.irq      = ~fifo_empty;

endmodule
